// File: rtl/decrementer_counter_if.sv
// rtl/decrementer_counter_if.sv - control and status bundle for decrementer_counter
interface decrementer_counter_if #(
  parameter int SIZE = 32
);
  logic            clear;
  logic            load;
  logic [SIZE-1:0] load_value;
  logic            valid;
  logic [SIZE-1:0] out;
  logic            busy;
  logic            done;

  modport master (
    output clear, load, load_value, valid,
    input  out, busy, done
  );

  modport slave (
    input  clear, load, load_value, valid,
    output out, busy, done
  );
endinterface

// File: rtl/decrementer_counter.sv
// rtl/decrementer_counter.sv - loadable down-counter with terminal-count pulse; DECREMENTER_AUTO_RELOAD_EN adds auto-reload
module decrementer_counter #(
  parameter int SIZE = 32,
  parameter int STEP = 1
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  decrementer_counter_if.slave bus
);

  localparam logic [SIZE-1:0] STEP_V = SIZE'(STEP);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] out_q, out_d;
  logic            done_q, done_d;
  logic            valid_en;

`ifdef DECREMENTER_AUTO_RELOAD_EN
  logic [SIZE-1:0] reload_q, reload_d;
`endif

  // X or Z on valid must never advance the count
  assign valid_en = (bus.valid === 1'b1);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    done_d  = 1'b0;
`ifdef DECREMENTER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.clear) begin
      state_d = IDLE;
      out_d   = '0;
    end else if (bus.load) begin
      out_d = bus.load_value;
      if (bus.load_value != '0) begin
        state_d = COUNT;
`ifdef DECREMENTER_AUTO_RELOAD_EN
        reload_d = bus.load_value;
`endif
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (state_q == COUNT && valid_en) begin
      if (out_q > STEP_V) begin
        out_d = out_q - STEP_V;
      end else begin
        // terminal count saturates rather than wrapping
        done_d = 1'b1;
`ifdef DECREMENTER_AUTO_RELOAD_EN
        out_d = reload_q;
`else
        out_d   = '0;
        state_d = IDLE;
`endif
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      out_q   <= '0;
      done_q  <= 1'b0;
`ifdef DECREMENTER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      done_q  <= done_d;
`ifdef DECREMENTER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = (state_q == COUNT);
  assign bus.done = done_q;

endmodule

// File: doc/decrementer_counter.md
Name: decrementer_counter

Overview:
- Loadable, clock-enabled down-counter. It is the down-counting counterpart of the team's combinational up-incrementer.
- Loaded with a start value, it decrements by STEP on every cycle that valid is high.
- It pulses done when it reaches zero, which makes it usable as a countdown timer or transfer-length counter.
- It sits beside the PC/address incrementers in the datapath and drives terminal-count events to control FSMs.

Parameters:
- SIZE, 32, width of the count value.
- STEP, 1, decrement amount per enabled cycle. Legal range is 1 to 2^SIZE-1.

Ports:
- PCLK  input  1  clock; all state updates on the rising edge.
- PRESETn  input  1  reset.
- clear  input  1  abort: return to IDLE, out=0, no done pulse.
- load  input  1  load load_value and start counting.
- load_value  input  SIZE  start value captured on load.
- valid  input  1  decrement enable. Only an exact logic 1 enables; 0, X and Z are treated as deasserted.
- out  output  SIZE  current count (registered).
- busy  output  1  high while in COUNT.
- done  output  1  single-cycle terminal-count pulse (registered).

Behaviour:
- Interface: one clock, PCLK. Reset is synchronous and active-low, on PRESETn sampled at the PCLK rising edge.
- Reset values:
  - out=0, busy=0, done=0.
  - state=IDLE.
  - reload register=0.
- States:
  - IDLE: not counting; out holds its last value.
  - COUNT: decrementing.
- Input priority each edge: PRESETn low > clear > load > valid.
- done defaults to 0 every cycle unless set by a rule below.
- clear=1: next state IDLE, out<=0, busy<=0, done<=0. Valid from any state.
- load=1, load_value!=0 (any state): out<=load_value, reload<=load_value, state<=COUNT, busy<=1.
  - Load during COUNT restarts the count; no done is produced for the aborted count.
- load=1, load_value==0: out<=0, state<=IDLE, busy<=0, done<=1 for exactly one cycle.
- COUNT, valid=1, out>STEP: out<=out-STEP.
- COUNT, valid=1, out<=STEP (terminal): out<=0 (saturates, never wraps), done<=1, busy<=0, state<=IDLE.
  - done and out==0 are visible in the same cycle.
- COUNT, valid!=1: out, busy and state hold; done=0.
- IDLE, valid=1 with no load: no effect; out does not change.
- Latency: out reflects a load or decrement one cycle after the enabling edge. N enabled cycles after a load of N*STEP, done=1.
- Reset or clear in the middle of a count discards it; no done is generated.

Optional Feature:
- Macro: DECREMENTER_AUTO_RELOAD_EN.
- Defined:
  - At terminal count, out<=reload instead of 0; state stays COUNT and busy stays 1.
  - done still pulses for one cycle.
  - Counting continues until clear or reset; load replaces the reload value.
  - The load_value==0 rule is unchanged (done pulse, IDLE).
- Undefined: the reload register and its logic are absent; behaviour is as described above.

Test Plan:
- Reset: PRESETn=0 for 2 cycles with load=1, load_value=5 -> out=0, busy=0, done=0; the load is ignored.
- Basic count: load 3 (STEP=1), valid=1 continuously -> out 3,2,1,0 on successive cycles; done=1 only in the out=0 cycle; busy falls in that same cycle.
- Gating and saturation: STEP=4, load 10, valid pattern 1,0,1,1 -> out 10,6,6,2,0; done pulses once; out never wraps.
- Priority: in COUNT at out=7, assert clear, load (value 9) and valid together -> out=0, IDLE, no done. Next cycle load 9 alone -> out=9, busy=1.
- Zero load and restart:
  - load_value=0 -> done=1 for one cycle, busy stays 0.
  - Load 5, then reload 2 at out=3 -> count restarts at 2; exactly one done at the end.
- Auto-reload (macro defined): load 2, valid=1 for 6 cycles -> out 2,1,2,1,2,1 with wrap-backs at the terminal counts; done on each terminal; busy stays 1 until clear.
